// File: rtl/timer_pkg.sv
// Shared types for the round countdown: FSM state encoding and status byte layout.
// Pure declarations; no logic, no latency, no flow control.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int ST_RUN   = 0;
    localparam int ST_PAUSE = 1;
    localparam int ST_WARN  = 2;
    localparam int ST_EXP   = 3;

    function automatic logic [7:0] pack_status(input logic run, input logic paused,
                                               input logic warn, input logic exp);
        logic [7:0] s;
        s = 8'h00;
        s[ST_RUN]   = run;
        s[ST_PAUSE] = paused;
        s[ST_WARN]  = warn;
        s[ST_EXP]   = exp;
        return s;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an HPS level; combinational pulse, one register of history.
// No flow control; RESET_VAL=1 suppresses an edge for a level already high out of reset.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/round_timer_ctrl.sv
// Per-round one-second countdown sequencer with pause, warning and sticky expiry; 1-cycle start/pause latency.
// No backpressure: start edge overrides everything, expiry holds until an ack edge from the HPS.
module round_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TIME_W        = 7,
    parameter int WARN_SECS     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [TIME_W-1:0] set_time,
    input  logic              cmd_pause,
    input  logic              expire_ack,
    output logic [TIME_W-1:0] curr_time,
    output logic              running,
    output logic              warning,
    output logic              expired,
    output logic              tick,
    output logic [7:0]        status
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    timer_state_t      state, state_n;
    logic [PW-1:0]     presc, presc_n;
    logic [TIME_W-1:0] time_n;
    logic              tick_n;
    logic              warn_n;
    logic              start_edge;
    logic              ack_edge;

    rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
        .clk   (clk),
        .reset (reset),
        .level (cmd_start),
        .rise  (start_edge)
    );

    rise_detect #(.RESET_VAL(1'b1)) u_ack_rise (
        .clk   (clk),
        .reset (reset),
        .level (expire_ack),
        .rise  (ack_edge)
    );

    // The cycle that leaves PAUSE also counts, so a pause of N cycles delays the tick by exactly N.
    always_comb begin
        state_n = state;
        presc_n = presc;
        time_n  = curr_time;
        tick_n  = 1'b0;
        if (start_edge) begin
            time_n  = set_time;
            presc_n = '0;
            state_n = (set_time == '0) ? EXPIRED : RUN;
        end else begin
            case (state)
                RUN, PAUSE: begin
                    if (cmd_pause) begin
                        state_n = PAUSE;
                    end else begin
                        state_n = RUN;
                        if (presc == PRESC_LAST) begin
                            presc_n = '0;
                            if (curr_time != '0) begin
                                time_n = curr_time - 1'b1;
                                tick_n = 1'b1;
                                if (curr_time == TIME_W'(1)) begin
                                    state_n = EXPIRED;
                                end
                            end
                        end else begin
                            presc_n = presc + 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    time_n  = '0;
                    presc_n = '0;
                    if (ack_edge) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    presc_n = '0;
                end
            endcase
        end
    end

    assign warn_n = (state_n == RUN) && (time_n <= TIME_W'(WARN_SECS)) && (time_n != '0);

    // Outputs are computed from next-state values so they move in lockstep with curr_time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            curr_time <= '0;
            running   <= 1'b0;
            warning   <= 1'b0;
            expired   <= 1'b0;
            tick      <= 1'b0;
            status    <= 8'h00;
        end else begin
            state     <= state_n;
            presc     <= presc_n;
            curr_time <= time_n;
            running   <= (state_n == RUN);
            warning   <= warn_n;
            expired   <= (state_n == EXPIRED);
            tick      <= tick_n;
            status    <= pack_status(state_n == RUN, state_n == PAUSE, warn_n, state_n == EXPIRED);
        end
    end

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Randomized and directed checks of round_timer_ctrl against an elapsed-time reference model.
module tb_round_timer_ctrl;

    localparam int T    = 4;
    localparam int WARN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_start;
    logic [6:0] set_time;
    logic       cmd_pause;
    logic       expire_ack;
    logic [6:0] curr_time;
    logic       running;
    logic       warning;
    logic       expired;
    logic       tick;
    logic [7:0] status;

    int total = 0;
    int bad   = 0;

    round_timer_ctrl #(.TICKS_PER_SEC(T), .TIME_W(7), .WARN_SECS(WARN)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_start  (cmd_start),
        .set_time   (set_time),
        .cmd_pause  (cmd_pause),
        .expire_ack (expire_ack),
        .curr_time  (curr_time),
        .running    (running),
        .warning    (warning),
        .expired    (expired),
        .tick       (tick),
        .status     (status)
    );

    always #5 clk = ~clk;

    wire [18:0] obs = {curr_time, running, warning, expired, tick, status};

    // Reference: mode 0 idle, 1 run, 2 paused, 3 expired; remaining time derived from
    // the number of unpaused cycles elapsed since the last start.
    int   m_mode;
    int   m_set;
    int   m_elapsed;
    int   m_time;
    logic m_tick;
    logic m_prev_start;
    logic m_prev_ack;

    task automatic model_step(input logic r, input logic s, input logic [6:0] v,
                              input logic p, input logic a);
        logic se, ae;
        if (r) begin
            m_mode = 0; m_set = 0; m_elapsed = 0; m_time = 0; m_tick = 1'b0;
            m_prev_start = 1'b1; m_prev_ack = 1'b1;
            return;
        end
        se = s && !m_prev_start;
        ae = a && !m_prev_ack;
        m_prev_start = s;
        m_prev_ack   = a;
        m_tick = 1'b0;
        if (se) begin
            m_set = int'(v); m_elapsed = 0; m_time = int'(v);
            m_mode = (v == 0) ? 3 : 1;
        end else if (m_mode == 1 || m_mode == 2) begin
            if (p) begin
                m_mode = 2;
            end else begin
                m_mode = 1;
                m_elapsed++;
                if (m_elapsed % T == 0 && m_time > 0) begin
                    m_time = m_set - m_elapsed / T;
                    m_tick = 1'b1;
                    if (m_time == 0) m_mode = 3;
                end
            end
        end else if (m_mode == 3 && ae) begin
            m_mode = 0;
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic run, pau, ex, wr;
        run = (m_mode == 1);
        pau = (m_mode == 2);
        ex  = (m_mode == 3);
        wr  = run && m_time <= WARN && m_time != 0;
        return {7'(m_time), run, wr, ex, m_tick, 4'h0, ex, wr, pau, run};
    endfunction

    task automatic cyc(input logic r, input logic s, input logic [6:0] v,
                       input logic p, input logic a);
        reset = r; cmd_start = s; set_time = v; cmd_pause = p; expire_ack = a;
        @(posedge clk);
        model_step(r, s, v, p, a);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 1, 7'd9, 0, 1);
        cyc(1, 1, 7'd9, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 7'd9, 0, 1);
            total++;
            if (curr_time !== 7'd0 || status !== 8'h00 || tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got time=%0d status=%h tick=%b want time=0 status=00 tick=0",
                         i, curr_time, status, tick);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_model cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_countdown();
        int ticks_at[$];
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 1, 7'd3, 0, 0);
        total++;
        if (curr_time !== 7'd3 || running !== 1'b1) begin
            bad++;
            $display("FAIL start_latency got time=%0d run=%b want time=3 run=1", curr_time, running);
        end
        for (int n = 1; n <= 14; n++) begin
            cyc(0, 1, 7'd3, 0, 0);
            if (tick === 1'b1) ticks_at.push_back(n);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL countdown n=%0d got=%h want=%h", n, obs, exp_vec());
            end
        end
        total++;
        if (ticks_at.size() != 3 || ticks_at[0] != 4 || ticks_at[1] != 8 || ticks_at[2] != 12) begin
            bad++;
            $display("FAIL tick_times got count=%0d want ticks at 4 8 12", ticks_at.size());
        end
        total++;
        if (status !== 8'h08 || expired !== 1'b1 || curr_time !== 7'd0) begin
            bad++;
            $display("FAIL expire_state got status=%h exp=%b time=%0d want 08 1 0", status, expired, curr_time);
        end
    endtask

    task automatic test_ack();
        cyc(0, 0, 7'd0, 0, 1);
        total++;
        if (status !== 8'h00 || expired !== 1'b0) begin
            bad++;
            $display("FAIL ack_clear got status=%h want 00", status);
        end
        // Ack held high across a fresh expiry must not clear it.
        cyc(0, 1, 7'd0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 7'd0, 0, 1);
            total++;
            if (status !== 8'h08 || tick !== 1'b0 || obs !== exp_vec()) begin
                bad++;
                $display("FAIL ack_held cyc=%0d got=%h want status=08 (%h)", i, obs, exp_vec());
            end
        end
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 0, 7'd0, 0, 1);
        total++;
        if (status !== 8'h00 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL ack_second got=%h want status=00 (%h)", obs, exp_vec());
        end
    endtask

    task automatic test_zero_start();
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 1, 7'd0, 0, 0);
        total++;
        if (expired !== 1'b1 || tick !== 1'b0 || running !== 1'b0 || status !== 8'h08) begin
            bad++;
            $display("FAIL zero_start got exp=%b tick=%b run=%b status=%h want 1 0 0 08",
                     expired, tick, running, status);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 7'd0, 0, 0);
            total++;
            if (tick !== 1'b0 || obs !== exp_vec()) begin
                bad++;
                $display("FAIL zero_hold cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        cyc(0, 0, 7'd0, 0, 1);
    endtask

    task automatic test_pause();
        int gap;
        logic seen_pause;
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 1, 7'd6, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 7'd6, 0, 0);
        total++;
        if (tick !== 1'b1 || curr_time !== 7'd5) begin
            bad++;
            $display("FAIL pause_first_tick got tick=%b time=%0d want 1 5", tick, curr_time);
        end
        gap = 0;
        seen_pause = 1'b0;
        cyc(0, 1, 7'd6, 0, 0); gap++;
        cyc(0, 1, 7'd6, 0, 0); gap++;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 7'd6, 1, 0); gap++;
            if (status[1] === 1'b1) seen_pause = 1'b1;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        for (int i = 0; i < 20 && tick !== 1'b1; i++) begin
            cyc(0, 1, 7'd6, 0, 0); gap++;
        end
        total++;
        if (gap != 9 || !seen_pause) begin
            bad++;
            $display("FAIL pause_gap got gap=%0d paused_seen=%b want gap=9 paused_seen=1", gap, seen_pause);
        end
    endtask

    task automatic test_start_on_tick();
        int gap;
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 1, 7'd3, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 7'd3, 0, 0);
        cyc(0, 1, 7'd5, 0, 0);
        total++;
        if (curr_time !== 7'd5 || tick !== 1'b0 || running !== 1'b1 || obs !== exp_vec()) begin
            bad++;
            $display("FAIL start_on_tick got time=%0d tick=%b run=%b want 5 0 1", curr_time, tick, running);
        end
        gap = 0;
        for (int i = 0; i < 10 && tick !== 1'b1; i++) begin
            cyc(0, 1, 7'd5, 0, 0); gap++;
        end
        total++;
        if (gap != 4 || curr_time !== 7'd4) begin
            bad++;
            $display("FAIL restart_tick got gap=%0d time=%0d want gap=4 time=4", gap, curr_time);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 7'd0, 0, 0);
        cyc(0, 1, 7'd5, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 7'd5, 0, 0);
        cyc(1, 1, 7'd5, 0, 0);
        total++;
        if (obs !== 19'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=00000", obs);
        end
        cyc(0, 1, 7'd5, 0, 0);
        total++;
        if (obs !== exp_vec() || running !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic s, p, a, r;
        logic [6:0] v;
        s = 1'b0; p = 1'b0; a = 1'b0;
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            if ($urandom_range(0, 5) == 0) p = ~p;
            if ($urandom_range(0, 7) == 0) a = ~a;
            v = 7'($urandom_range(0, 6));
            cyc(r, s, v, p, a);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random n=%0d got=%h want=%h", n, obs, exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_start = 1'b0; set_time = 7'd0; cmd_pause = 1'b0; expire_ack = 1'b0;
        model_step(1, 0, 7'd0, 0, 0);
        test_reset();
        test_countdown();
        test_ack();
        test_zero_start();
        test_pause();
        test_start_on_tick();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_timer_ctrl.md
# round_timer_ctrl

Sequencer for the per-round countdown shown on the canvas. It takes the HPS timer PIO word (start level plus preset seconds) and a pause level, and runs a prescaled one-second countdown. It drives `time_num` to the canvas and returns a packed status byte to the HPS, including a sticky expiry flag the HPS must acknowledge. It replaces free-running prescaler logic at top level with an explicit state machine.

## Interface
Parameters:
- `TICKS_PER_SEC`, 50_000_000: clk cycles per countdown second.
- `TIME_W`, 7: width of time values.
- `WARN_SECS`, 5: `warning` asserts when running and `curr_time` <= this value.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain); one clock.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_start`  in  1  level from HPS; a rising edge loads and starts the timer.
- `set_time`  in  TIME_W  preset seconds, sampled on the start edge.
- `cmd_pause`  in  1  level; while high, counting is frozen.
- `expire_ack`  in  1  level from HPS; a rising edge clears EXPIRED.
- `curr_time`  out  TIME_W  remaining seconds.
- `running`  out  1  high in RUN.
- `warning`  out  1  running && `curr_time` <= WARN_SECS && `curr_time` != 0.
- `expired`  out  1  sticky; high in EXPIRED.
- `tick`  out  1  one-cycle pulse on each decrement.
- `status`  out  8  bit 0 running, bit 1 paused, bit 2 warning, bit 3 expired, bits 7:4 zero.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Edge detection: `start_edge = cmd_start & ~start_q`. `ack_edge` is formed the same way from `ack_q`.
- Start edge, from any state:
  - `curr_time` <= `set_time`; prescaler <= 0.
  - Next state is RUN, or EXPIRED if `set_time` == 0.
  - Start has priority over pause, tick and ack in the same cycle.
- RUN:
  - Prescaler counts 0 to TICKS_PER_SEC-1.
  - At terminal count: prescaler wraps to 0, `curr_time` decrements, `tick` pulses.
  - If `curr_time` was 1 at that terminal count, the next state is EXPIRED and `curr_time` = 0.
- RUN with `cmd_pause` high: go to PAUSE. The prescaler holds its value and no tick is issued that cycle.
- PAUSE with `cmd_pause` low: return to RUN and resume from the held prescaler value.
- EXPIRED:
  - `curr_time` stays at 0.
  - Ack edge → IDLE. An ack edge in any other state is ignored.
- IDLE: `curr_time` holds its last value; the prescaler is idle at 0.
- `curr_time` never underflows; decrement occurs only when it is nonzero.
- Prescaler width: $clog2(TICKS_PER_SEC).

## Timing
- Reset values:
  - state IDLE; `curr_time` 0; `running`, `warning`, `expired`, `tick` all 0; `status` 0x00; prescaler 0.
  - `start_q` and `ack_q` reset to 1, so a level held high through reset does not trigger until it falls and rises again.
- Start latency is one cycle: if `cmd_start` is first sampled high at edge k, then after edge k `curr_time` = `set_time` and `running` = 1.
- First `tick` fires TICKS_PER_SEC cycles after the start edge; subsequent ticks are spaced exactly TICKS_PER_SEC cycles apart while in RUN.
- Pause latency is one cycle. Time spent in PAUSE extends the next tick by the same number of cycles.
- All outputs are registered. `warning` and `status` update in the same cycle as `curr_time` and state.
- Reset mid-count returns everything to its reset values on the next edge.

## Structure
- Package `timer_pkg`:
  - `timer_state_t` enum (IDLE, RUN, PAUSE, EXPIRED).
  - Status bit-index localparams (`ST_RUN`=0, `ST_PAUSE`=1, `ST_WARN`=2, `ST_EXP`=3).
- Sub-module `rise_detect`: one register plus AND, with a reset value parameter. Instantiated twice, for start and ack.
- Top level connects `{start_timer, set_timer}` to `cmd_start`/`set_time`, `curr_time` to the canvas `time_num`, and `status` to a new HPS PIO.

## Test plan
All scenarios use TICKS_PER_SEC=4 and WARN_SECS=2.
- Reset with `cmd_start` held high, then keep it high → no start; `curr_time` 0; `status` 0x00.
- Start edge with `set_time`=3 → after 1 cycle `curr_time`=3 and `running`=1. Ticks occur at cycles 4, 8, 12, and `curr_time` steps 2, 1, 0. `warning` is high at 2 and 1. At 0, `expired`=1 and `status`=0x08.
- Assert pause 2 cycles after a tick for 5 cycles → `status` bit 1 set. The next tick arrives 9 cycles after the previous one rather than 4.
- In EXPIRED, pulse `expire_ack` → state IDLE, `status` 0x00. Hold ack high and issue a second ack with no low between → nothing happens.
- Start edge with `set_time`=0 → EXPIRED after 1 cycle and no tick is issued.
- Start edge (`set_time`=5) in the same cycle as a terminal tick in RUN → `curr_time`=5, prescaler 0, no tick pulse.
